// File: rtl/sig_misr_pkg.sv
// Shared MISR definitions: FSM states, default feedback taps and seed, and the
// signature step function also used by the CRC_OUT generator.
package sig_misr_pkg;

  localparam int unsigned     SIG_W    = 32;
  localparam logic [SIG_W-1:0] DEF_POLY = 32'h0001_0811;
  localparam logic [SIG_W-1:0] DEF_SEED = 32'h0000_0000;

  typedef logic [SIG_W-1:0] sig_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } state_t;

  // One MISR step: shift left, fold the outgoing MSB back through the taps, absorb data.
  function automatic sig_t misr_next(input sig_t sig, input sig_t data, input sig_t poly);
    return {sig[SIG_W-2:0], 1'b0} ^ (sig[SIG_W-1] ? poly : '0) ^ data;
  endfunction

endpackage

// File: rtl/sig_misr_core.sv
// Signature register: i_load restores SEED, i_en absorbs i_data in one cycle.
// No backpressure; the caller decides when a word is absorbed.
module sig_misr_core
  import sig_misr_pkg::*;
#(
  parameter int unsigned      WIDTH = SIG_W,
  parameter logic [WIDTH-1:0] POLY  = WIDTH'(DEF_POLY),
  parameter logic [WIDTH-1:0] SEED  = WIDTH'(DEF_SEED)
) (
  input  logic             CK,
  input  logic             RESET,
  input  logic             i_load,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_sig
);

  logic [WIDTH-1:0] r_sig;
  logic [WIDTH-1:0] w_next;

  generate
    if (WIDTH == SIG_W) begin : g_pkg_step
      assign w_next = misr_next(r_sig, i_data, POLY);
    end else begin : g_generic_step
      assign w_next = {r_sig[WIDTH-2:0], 1'b0} ^ (r_sig[WIDTH-1] ? POLY : '0) ^ i_data;
    end
  endgenerate

  always_ff @(posedge CK or negedge RESET) begin
    if (!RESET) begin
      r_sig <= SEED;
    end else if (i_load) begin
      r_sig <= SEED;
    end else if (i_en) begin
      r_sig <= w_next;
    end
  end

  assign o_sig = r_sig;

endmodule

// File: rtl/sig_misr_checker.sv
// MISR response checker: done rises 2 edges after the final beat; in_ready=1 only in ACCUM.
// Optional idle watchdog with err_timeout under SIG_CHECK_TIMEOUT_EN.
module sig_misr_checker
  import sig_misr_pkg::*;
#(
  parameter int unsigned      WIDTH = SIG_W,
  parameter logic [WIDTH-1:0] POLY  = WIDTH'(DEF_POLY),
  parameter logic [WIDTH-1:0] SEED  = WIDTH'(DEF_SEED),
  parameter int unsigned      LEN_W = 16
`ifdef SIG_CHECK_TIMEOUT_EN
  , parameter int unsigned    TMO_CYC = 1024
`endif
) (
  input  logic             CK,
  input  logic             RESET,
  input  logic             start,
  input  logic [LEN_W-1:0] frame_len,
  input  logic [WIDTH-1:0] golden_sig,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [WIDTH-1:0] sig_out
`ifdef SIG_CHECK_TIMEOUT_EN
  , output logic           err_timeout
`endif
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [LEN_W-1:0] r_remaining;
  logic [WIDTH-1:0] r_golden;
  logic             r_pass;
  logic [WIDTH-1:0] w_sig;
  logic             w_start_acc;
  logic             w_beat;
  logic             w_final;
  logic             w_tmo;

  assign w_start_acc = start & ((r_state == IDLE) | (r_state == DONE));
  assign w_beat      = in_valid & in_ready;
  // Exiting on remaining==1 keeps the counter from ever wrapping, even at the max length.
  assign w_final     = w_beat & (r_remaining == LEN_W'(1));

  always_ff @(posedge CK or negedge RESET) begin
    if (!RESET) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    case (r_state)
      IDLE, DONE: begin
        done = (r_state == DONE);
        if (start) begin
          w_state_nxt = (frame_len == '0) ? CHECK : ACCUM;
        end
      end
      ACCUM: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (w_final) begin
          w_state_nxt = CHECK;
        end else if (w_tmo) begin
          w_state_nxt = DONE;
        end
      end
      CHECK: begin
        busy        = 1'b1;
        w_state_nxt = DONE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CK or negedge RESET) begin
    if (!RESET) begin
      r_remaining <= '0;
      r_golden    <= '0;
      r_pass      <= 1'b0;
    end else if (w_start_acc) begin
      r_remaining <= frame_len;
      r_golden    <= golden_sig;
      r_pass      <= 1'b0;
    end else begin
      if (w_beat) begin
        r_remaining <= r_remaining - LEN_W'(1);
      end
      if (r_state == CHECK) begin
        r_pass <= (w_sig == r_golden);
      end else if (w_tmo) begin
        r_pass <= 1'b0;
      end
    end
  end

`ifdef SIG_CHECK_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TMO_CYC + 1);

  logic [TMO_W-1:0] r_idle_cnt;
  logic             r_err_timeout;

  assign w_tmo = (r_state == ACCUM) & ~in_valid & (r_idle_cnt == TMO_W'(TMO_CYC - 1));

  always_ff @(posedge CK or negedge RESET) begin
    if (!RESET) begin
      r_idle_cnt    <= '0;
      r_err_timeout <= 1'b0;
    end else if (w_start_acc) begin
      r_idle_cnt    <= '0;
      r_err_timeout <= 1'b0;
    end else if (w_tmo) begin
      r_idle_cnt    <= '0;
      r_err_timeout <= 1'b1;
    end else if (w_beat) begin
      r_idle_cnt <= '0;
    end else if ((r_state == ACCUM) && !in_valid) begin
      r_idle_cnt <= r_idle_cnt + TMO_W'(1);
    end
  end

  assign err_timeout = r_err_timeout;
`else
  assign w_tmo = 1'b0;
`endif

  sig_misr_core #(
    .WIDTH (WIDTH),
    .POLY  (POLY),
    .SEED  (SEED)
  ) u_core (
    .CK     (CK),
    .RESET  (RESET),
    .i_load (w_start_acc),
    .i_en   (w_beat),
    .i_data (in_data),
    .o_sig  (w_sig)
  );

  assign sig_out = w_sig;
  assign pass    = r_pass;

endmodule
